// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory load controller.
package imem_pkg;
  localparam int          DEPTH_DEF = 64;
  localparam int          AW_DEF    = 6;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;
endpackage

// File: rtl/imem_load_ctrl_if.sv
// Loader byte stream, core fetch port and instruction-memory port of imem_load_ctrl.
interface imem_load_ctrl_if #(parameter int AW = imem_pkg::AW_DEF);
  logic          load_start;
  logic [AW:0]   load_len;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          core_hold;
  logic          load_done;
  logic          core_req;
  logic [31:0]   core_addr;
  logic          core_valid;
  logic [31:0]   core_instr;
  logic          core_fault;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_re;
  logic [31:0]   mem_rdata;

  modport master (
    input  load_start, load_len, byte_valid, byte_data, core_req, core_addr, mem_rdata,
    output byte_ready, core_hold, load_done, core_valid, core_instr, core_fault,
           mem_we, mem_addr, mem_wdata, mem_re
  );

  modport slave (
    output load_start, load_len, byte_valid, byte_data, core_req, core_addr, mem_rdata,
    input  byte_ready, core_hold, load_done, core_valid, core_instr, core_fault,
           mem_we, mem_addr, mem_wdata, mem_re
  );
endinterface

// File: rtl/byte_packer.sv
// Assembles four loader bytes into a little-endian word; word/word_valid are
// combinational so the write can be registered on the 4th-byte edge.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [1:0]  cnt;
  logic [31:0] acc;

  always_comb begin
    word = acc;
    word[{cnt, 3'b000} +: 8] = byte_data;
  end

  assign word_valid = byte_en && (cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (clr) begin
      cnt <= '0;
      acc <= '0;
    end else if (byte_en) begin
      cnt <= cnt + 2'd1;
      acc <= word_valid ? '0 : word;
    end
  end
endmodule

// File: rtl/imem_load_ctrl.sv
// Loads a program into instruction memory after reset, then serves core
// fetches with one-cycle latency and misalign/range fault reporting.
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input logic              clk,
  input logic              reset_n,
  imem_load_ctrl_if.master bus
);
  state_e        state;
  logic [AW:0]   wlen, wcnt, wcnt_nx, len_c;
  logic [AW-1:0] waddr;
  logic [31:0]   instr_q, word;
  logic          rd_pend, word_valid, accept, start, fetch_ok, fault;

  assign bus.byte_ready = (state == LOAD);
  assign accept         = bus.byte_valid & bus.byte_ready;
  assign start          = bus.load_start & (state != LOAD);
  assign len_c          = (bus.load_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.load_len;
  assign wcnt_nx        = wcnt + (AW+1)'(1);

  // Requests while core_hold is still high (final-write cycle) are dropped,
  // which keeps mem_re and mem_we mutually exclusive.
  assign fault    = (bus.core_addr[1:0] != 2'b00) || (bus.core_addr[31:2] >= 30'(DEPTH));
  assign fetch_ok = (state == RUN) & ~bus.core_hold & bus.core_req & ~bus.load_start;

  // The synchronous-read array returns data one cycle after mem_re, so the
  // read is issued in the request cycle and its data passed straight through.
  assign bus.mem_re     = fetch_ok & ~fault;
  assign bus.mem_addr   = fetch_ok ? bus.core_addr[AW+1:2] : waddr;
  assign bus.core_instr = rd_pend ? bus.mem_rdata : instr_q;

  byte_packer u_pack (
    .clk       (clk),
    .rst_n     (reset_n),
    .clr       (start),
    .byte_en   (accept),
    .byte_data (bus.byte_data),
    .word_valid(word_valid),
    .word      (word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      wlen           <= '0;
      wcnt           <= '0;
      waddr          <= '0;
      instr_q        <= '0;
      rd_pend        <= 1'b0;
      bus.core_hold  <= 1'b1;
      bus.load_done  <= 1'b0;
      bus.core_valid <= 1'b0;
      bus.core_fault <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_wdata  <= '0;
    end else begin
      bus.load_done  <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.core_hold  <= !((state == RUN) && !bus.load_start);
      bus.core_valid <= fetch_ok;
      bus.core_fault <= fetch_ok & fault;
      rd_pend        <= fetch_ok & ~fault;
      instr_q        <= (fetch_ok & fault) ? NOP_INSTR : 32'h0;

      if (start) begin
        wcnt  <= '0;
        waddr <= '0;
        wlen  <= len_c;
        if (len_c == '0) begin
          state         <= RUN;
          bus.load_done <= 1'b1;
        end else begin
          state <= LOAD;
        end
      end else if ((state == LOAD) && word_valid) begin
        bus.mem_we    <= 1'b1;
        bus.mem_wdata <= word;
        waddr         <= wcnt[AW-1:0];
        wcnt          <= wcnt_nx;
        if (wcnt_nx == wlen) begin
          state         <= RUN;
          bus.load_done <= 1'b1;
        end
      end
    end
  end
endmodule
